// File: rtl/sdram_arbit_pkg.sv
// sdram_arbit_pkg: SDRAM command codes, idle bus constants and arbiter state types shared with the engines
package sdram_arbit_pkg;

    // Commands as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_BSTOP     = 4'b0110;

    // Bank/address driven while nobody owns the bus
    localparam logic [1:0]  IDLE_BA   = 2'b11;
    localparam logic [12:0] IDLE_ADDR = 13'h1FFF;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_ARBIT = 5'b00010,
        ST_AREF  = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_READ  = 5'b10000
    } state_e;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

endpackage

// File: rtl/sdram_arbit_if.sv
// sdram_arbit_if: SDRAM pad-side command/address/data bus driven by the arbiter
interface sdram_arbit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2
) ();
    logic              o_sdram_cke;
    logic              o_sdram_cs_n;
    logic              o_sdram_ras_n;
    logic              o_sdram_cas_n;
    logic              o_sdram_we_n;
    logic [BA_W-1:0]   o_sdram_ba;
    logic [ADDR_W-1:0] o_sdram_addr;
    logic              o_sdram_dq_oe;
    logic [DATA_W-1:0] o_sdram_dq_out;

    modport master (
        output o_sdram_cke, o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n,
        output o_sdram_ba, o_sdram_addr, o_sdram_dq_oe, o_sdram_dq_out
    );

    modport slave (
        input o_sdram_cke, o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n,
        input o_sdram_ba, o_sdram_addr, o_sdram_dq_oe, o_sdram_dq_out
    );
endinterface

// File: rtl/sdram_arbit.sv
// sdram_arbit: shares the SDRAM pins between init, refresh, write and read engines (refresh first, write/read round-robin)
module sdram_arbit
    import sdram_arbit_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2
) (
    input  logic              i_sysclk,
    input  logic              i_sysrst_n,
    input  logic [3:0]        i_init_cmd,
    input  logic [BA_W-1:0]   i_init_ba,
    input  logic [ADDR_W-1:0] i_init_addr,
    input  logic              i_init_done,
    input  logic              i_aref_req,
    input  logic [3:0]        i_aref_cmd,
    input  logic [BA_W-1:0]   i_aref_ba,
    input  logic [ADDR_W-1:0] i_aref_addr,
    input  logic              i_aref_done,
    input  logic              i_wr_req,
    input  logic [3:0]        i_wr_cmd,
    input  logic [BA_W-1:0]   i_wr_ba,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_wr_sdram_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_done,
    input  logic              i_rd_req,
    input  logic [3:0]        i_rd_cmd,
    input  logic [BA_W-1:0]   i_rd_ba,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_rd_done,
    output logic              o_aref_en,
    output logic              o_wr_en,
    output logic              o_rd_en,
    sdram_arbit_if.master     bus
);

    state_e            r_state;
    state_e            w_next_state;
    grant_e            r_last_grant;
    grant_e            w_next_grant;
    logic [3:0]        w_cmd;
    logic [BA_W-1:0]   w_ba;
    logic [ADDR_W-1:0] w_addr;
    logic              w_dq_oe;

    // State and grant-history registers; last grant resets to READ so write wins the first contest
    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GRANT_RD;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_grant;
        end
    end

    // Next state: refresh beats data engines; contested write/read alternate; only the owner's done returns to ARBIT
    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_last_grant;
        case (r_state)
            ST_IDLE:  if (i_init_done) w_next_state = ST_ARBIT;
            ST_ARBIT: begin
                if (i_aref_req) begin
                    w_next_state = ST_AREF;
                end else if (i_wr_req && (!i_rd_req || r_last_grant == GRANT_RD)) begin
                    w_next_state = ST_WRITE;
                    w_next_grant = GRANT_WR;
                end else if (i_rd_req) begin
                    w_next_state = ST_READ;
                    w_next_grant = GRANT_RD;
                end
            end
            ST_AREF:  if (i_aref_done) w_next_state = ST_ARBIT;
            ST_WRITE: if (i_wr_done) w_next_state = ST_ARBIT;
            ST_READ:  if (i_rd_done) w_next_state = ST_ARBIT;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Bus mux: owning engine's already-registered outputs pass straight through; NOP otherwise and during reset
    always_comb begin
        w_cmd  = CMD_NOP;
        w_ba   = '1;
        w_addr = '1;
        if (i_sysrst_n) begin
            case (r_state)
                ST_IDLE:  {w_cmd, w_ba, w_addr} = {i_init_cmd, i_init_ba, i_init_addr};
                ST_AREF:  {w_cmd, w_ba, w_addr} = {i_aref_cmd, i_aref_ba, i_aref_addr};
                ST_WRITE: {w_cmd, w_ba, w_addr} = {i_wr_cmd, i_wr_ba, i_wr_addr};
                ST_READ:  {w_cmd, w_ba, w_addr} = {i_rd_cmd, i_rd_ba, i_rd_addr};
                default:  {w_cmd, w_ba, w_addr} = {CMD_NOP, {BA_W{1'b1}}, {ADDR_W{1'b1}}};
            endcase
        end
    end

    assign o_aref_en = (r_state == ST_AREF);
    assign o_wr_en   = (r_state == ST_WRITE);
    assign o_rd_en   = (r_state == ST_READ);
    assign w_dq_oe   = (r_state == ST_WRITE) && i_wr_sdram_en;

    assign bus.o_sdram_cke    = 1'b1;
    assign {bus.o_sdram_cs_n, bus.o_sdram_ras_n, bus.o_sdram_cas_n, bus.o_sdram_we_n} = w_cmd;
    assign bus.o_sdram_ba     = w_ba;
    assign bus.o_sdram_addr   = w_addr;
    assign bus.o_sdram_dq_oe  = w_dq_oe;
    assign bus.o_sdram_dq_out = w_dq_oe ? i_wr_data : '0;

endmodule
